// File: rtl/stage_f_if.sv
// -----------------------------------------------------------------------------
// stage_f_if -- Wishbone-classic instruction bus between stage_f and
// instruction memory.
//   i_adr_o  64  fetch address (driven by stage_f)
//   i_cyc_o   1  bus cycle in progress
//   i_stb_o   1  strobe, mirrors i_cyc_o
//   i_ack_i   1  memory acknowledge, may be zero-wait
//   i_dat_i  32  instruction word, valid with i_ack_i
//   i_err_i   1  bus error
// Modports: master (stage_f side), slave (memory side).
// -----------------------------------------------------------------------------
interface stage_f_if;
   logic [63:0] i_adr_o;
   logic        i_cyc_o;
   logic        i_stb_o;
   logic        i_ack_i;
   logic [31:0] i_dat_i;
   logic        i_err_i;

   modport master (
      output i_adr_o, i_cyc_o, i_stb_o,
      input  i_ack_i, i_dat_i, i_err_i
   );

   modport slave (
      input  i_adr_o, i_cyc_o, i_stb_o,
      output i_ack_i, i_dat_i, i_err_i
   );
endinterface

// File: rtl/stage_f.sv
// -----------------------------------------------------------------------------
// stage_f -- instruction fetch stage. Owns the PC, issues single-beat
// Wishbone-classic reads and hands each accepted word to the decoder as a
// one-cycle f_ack_o strobe. Redirects from execute retarget the PC; a fetch
// already in flight when a redirect arrives is completed on the bus and
// then thrown away.
//
// Ports:
//   clk_i         pipeline clock
//   reset_ni      asynchronous active-low reset
//   bus           stage_f_if.master instruction bus
//   x_redirect_i  one-cycle redirect request, x_pc_i is its target
//   f_ack_o       instruction valid to decoder (combinational from i_ack_i)
//   f_dat_o       instruction word, f_pc_o its address
//   f_misalign_o  halted on a target with [1:0] != 0
//   f_fault_o     halted on a bus error
//
// Build option: STAGE_F_BUS_ERR_EN -- honour i_err_i (halt with f_fault_o).
// Without it i_err_i is ignored and f_fault_o stays 0.
// -----------------------------------------------------------------------------
module stage_f #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0100
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   stage_f_if.master   bus,
   input  logic        x_redirect_i,
   input  logic [63:0] x_pc_i,
   output logic        f_ack_o,
   output logic [31:0] f_dat_o,
   output logic [63:0] f_pc_o,
   output logic        f_misalign_o,
   output logic        f_fault_o
);

   typedef enum logic [1:0] {StIdle, StFetch, StHalt} state_e;

   state_e      r_state;
   logic [63:0] r_pc;
   logic        r_pend;
   logic [63:0] r_pend_pc;
   logic        r_misalign;
   logic        r_fault;

   logic        w_in_fetch;
   logic        w_ack;
   logic        w_err;
   logic        w_done;
   logic        w_stale;
   logic [63:0] w_tgt;
   logic        w_tgt_mis;

   assign w_in_fetch = (r_state == StFetch);
   assign w_ack      = w_in_fetch & bus.i_ack_i;

`ifdef STAGE_F_BUS_ERR_EN
   assign w_err      = w_in_fetch & bus.i_err_i;
`else
   logic w_unused_err;
   assign w_unused_err = bus.i_err_i;
   assign w_err        = 1'b0;
`endif

   assign w_done    = w_ack | w_err;
   // A completing fetch is stale if a redirect is already queued or lands now.
   assign w_stale   = r_pend | x_redirect_i;
   // The redirect arriving this cycle beats the queued one.
   assign w_tgt     = x_redirect_i ? x_pc_i : r_pend_pc;
   assign w_tgt_mis = |w_tgt[1:0];

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         r_state    <= StIdle;
         r_pc       <= RESET_PC;
         r_pend     <= 1'b0;
         r_pend_pc  <= '0;
         r_misalign <= 1'b0;
         r_fault    <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (x_redirect_i) begin
                  r_pc       <= w_tgt;
                  r_misalign <= w_tgt_mis;
                  r_fault    <= 1'b0;
                  r_state    <= w_tgt_mis ? StHalt : StFetch;
               end else begin
                  r_state <= StFetch;
               end
            end
            StFetch: begin
               if (w_done) begin
                  if (w_stale) begin
                     r_pc       <= w_tgt;
                     r_pend     <= 1'b0;
                     r_misalign <= w_tgt_mis;
                     r_state    <= w_tgt_mis ? StHalt : StFetch;
                  end else if (w_err) begin
                     r_fault <= 1'b1;
                     r_state <= StHalt;
                  end else begin
                     r_pc <= r_pc + 64'd4;
                  end
               end else if (x_redirect_i) begin
                  // Bus cycle keeps running; the target waits for the ack.
                  r_pend    <= 1'b1;
                  r_pend_pc <= x_pc_i;
               end
            end
            StHalt: begin
               if (x_redirect_i) begin
                  r_pc       <= w_tgt;
                  r_misalign <= w_tgt_mis;
                  r_fault    <= 1'b0;
                  r_state    <= w_tgt_mis ? StHalt : StFetch;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign bus.i_adr_o  = r_pc;
   assign bus.i_cyc_o  = w_in_fetch;
   assign bus.i_stb_o  = w_in_fetch;

   assign f_ack_o      = w_ack & ~w_err & ~w_stale;
   assign f_dat_o      = bus.i_dat_i;
   assign f_pc_o       = r_pc;
   assign f_misalign_o = r_misalign;
   assign f_fault_o    = r_fault;

endmodule

// File: tb/tb_stage_f.sv
// -----------------------------------------------------------------------------
// tb_stage_f -- directed test of stage_f. Inputs change 1 ns after the rising
// edge; outputs (including the combinational f_ack_o) are checked 2 ns later.
// -----------------------------------------------------------------------------
module tb_stage_f;

   logic        clk_i = 1'b0;
   logic        reset_ni;
   logic        x_redirect_i;
   logic [63:0] x_pc_i;
   logic        f_ack_o;
   logic [31:0] f_dat_o;
   logic [63:0] f_pc_o;
   logic        f_misalign_o;
   logic        f_fault_o;

   int n_vec = 0;
   int n_err = 0;

   stage_f_if bus ();

   stage_f #(
      .RESET_PC (64'h0000_0000_0000_0100)
   ) u_dut (
      .clk_i        (clk_i),
      .reset_ni     (reset_ni),
      .bus          (bus),
      .x_redirect_i (x_redirect_i),
      .x_pc_i       (x_pc_i),
      .f_ack_o      (f_ack_o),
      .f_dat_o      (f_dat_o),
      .f_pc_o       (f_pc_o),
      .f_misalign_o (f_misalign_o),
      .f_fault_o    (f_fault_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge, clear one-shot inputs.
   task automatic next_cyc();
      @(posedge clk_i);
      #1;
      x_redirect_i = 1'b0;
      bus.i_ack_i  = 1'b0;
      bus.i_err_i  = 1'b0;
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      reset_ni     = 1'b1;
      x_redirect_i = 1'b0;
      x_pc_i       = '0;
      bus.i_ack_i  = 1'b0;
      bus.i_dat_i  = '0;
      bus.i_err_i  = 1'b0;
      #1 reset_ni  = 1'b0;

      // Reset: two cycles low
      @(posedge clk_i);
      settle();
      check("rst_cyc", bus.i_cyc_o, 1'b0);
      check("rst_stb", bus.i_stb_o, 1'b0);
      check("rst_adr", bus.i_adr_o, 64'h100);
      check("rst_fack", f_ack_o, 1'b0);
      check("rst_mis", f_misalign_o, 1'b0);
      check("rst_flt", f_fault_o, 1'b0);
      @(posedge clk_i);
      #1 reset_ni = 1'b1;
      settle();
      check("idle_cyc", bus.i_cyc_o, 1'b0);

      // First strobe one cycle after release; zero-wait run of three
      next_cyc();
      check("first_cyc", bus.i_cyc_o, 1'b1);
      check("first_stb", bus.i_stb_o, 1'b1);
      check("first_adr", bus.i_adr_o, 64'h100);
      bus.i_ack_i = 1'b1; bus.i_dat_i = 32'h0000_0013;
      settle();
      check("zw0_ack", f_ack_o, 1'b1);
      check("zw0_pc", f_pc_o, 64'h100);
      check("zw0_dat", f_dat_o, 32'h0000_0013);
      next_cyc();
      bus.i_ack_i = 1'b1; bus.i_dat_i = 32'h0041_0113;
      settle();
      check("zw1_ack", f_ack_o, 1'b1);
      check("zw1_pc", f_pc_o, 64'h104);
      check("zw1_dat", f_dat_o, 32'h0041_0113);
      next_cyc();
      bus.i_ack_i = 1'b1; bus.i_dat_i = 32'h0020_8033;
      settle();
      check("zw2_ack", f_ack_o, 1'b1);
      check("zw2_pc", f_pc_o, 64'h108);
      check("zw2_dat", f_dat_o, 32'h0020_8033);

      // Two wait states at 0x10C
      for (int i = 0; i < 2; i++) begin
         next_cyc();
         settle();
         check("ws_adr", bus.i_adr_o, 64'h10C);
         check("ws_cyc", bus.i_cyc_o, 1'b1);
         check("ws_fack", f_ack_o, 1'b0);
      end
      next_cyc();
      bus.i_ack_i = 1'b1; bus.i_dat_i = 32'h0000_0033;
      settle();
      check("ws_ack", f_ack_o, 1'b1);
      check("ws_pc", f_pc_o, 64'h10C);
      next_cyc();
      settle();
      check("ws_next_adr", bus.i_adr_o, 64'h110);
      check("ws_one_ack", f_ack_o, 1'b0);

      // Redirect to 0x2000 during a wait state, stale ack discarded
      x_redirect_i = 1'b1; x_pc_i = 64'h2000;
      settle();
      check("rd_wait_fack", f_ack_o, 1'b0);
      next_cyc();
      bus.i_ack_i = 1'b1; bus.i_dat_i = 32'hFFFF_FFFF;
      settle();
      check("rd_stale_adr", bus.i_adr_o, 64'h110);
      check("rd_stale_fack", f_ack_o, 1'b0);
      next_cyc();
      settle();
      check("rd_new_adr", bus.i_adr_o, 64'h2000);
      check("rd_new_cyc", bus.i_cyc_o, 1'b1);
      bus.i_ack_i = 1'b1; bus.i_dat_i = 32'h0000_0013;
      settle();
      check("rd_new_fack", f_ack_o, 1'b1);
      check("rd_new_pc", f_pc_o, 64'h2000);

      // Redirect coinciding with a zero-wait ack at 0x2004
      next_cyc();
      bus.i_ack_i = 1'b1; bus.i_dat_i = 32'h1234_5678;
      x_redirect_i = 1'b1; x_pc_i = 64'h2100;
      settle();
      check("co_fack", f_ack_o, 1'b0);
      next_cyc();
      settle();
      check("co_adr", bus.i_adr_o, 64'h2100);

      // Misaligned target 0x2002 via wait-state redirect
      x_redirect_i = 1'b1; x_pc_i = 64'h2002;
      next_cyc();
      bus.i_ack_i = 1'b1;
      settle();
      check("mis_stale_fack", f_ack_o, 1'b0);
      next_cyc();
      settle();
      check("mis_flag", f_misalign_o, 1'b1);
      check("mis_cyc", bus.i_cyc_o, 1'b0);
      check("mis_adr", bus.i_adr_o, 64'h2002);
      for (int i = 0; i < 5; i++) begin
         bus.i_ack_i = 1'b1;
         settle();
         check("halt_fack", f_ack_o, 1'b0);
         check("halt_cyc", bus.i_cyc_o, 1'b0);
         next_cyc();
      end
      x_redirect_i = 1'b1; x_pc_i = 64'h3000;
      next_cyc();
      settle();
      check("exit_mis", f_misalign_o, 1'b0);
      check("exit_adr", bus.i_adr_o, 64'h3000);
      check("exit_cyc", bus.i_cyc_o, 1'b1);
      bus.i_ack_i = 1'b1; bus.i_dat_i = 32'h0000_0013;
      settle();
      check("exit_fack", f_ack_o, 1'b1);

      // Bus error pulsed at 0x3004
      next_cyc();
      bus.i_err_i = 1'b1;
      settle();
      check("err_adr", bus.i_adr_o, 64'h3004);
      check("err_fack", f_ack_o, 1'b0);
      next_cyc();
      settle();
`ifdef STAGE_F_BUS_ERR_EN
      check("err_fault", f_fault_o, 1'b1);
      check("err_cyc", bus.i_cyc_o, 1'b0);
      x_redirect_i = 1'b1; x_pc_i = 64'h4000;
      next_cyc();
      settle();
      check("err_clear", f_fault_o, 1'b0);
      check("err_exit_adr", bus.i_adr_o, 64'h4000);
`else
      check("noerr_fault", f_fault_o, 1'b0);
      check("noerr_cyc", bus.i_cyc_o, 1'b1);
      check("noerr_adr", bus.i_adr_o, 64'h3004);
      bus.i_ack_i = 1'b1; bus.i_dat_i = 32'h00A0_0093;
      settle();
      check("noerr_fack", f_ack_o, 1'b1);
      check("noerr_pc", f_pc_o, 64'h3004);
`endif

      // Reset mid-cycle with a pending redirect
      next_cyc();
      x_redirect_i = 1'b1; x_pc_i = 64'h5000;
      next_cyc();
      bus.i_ack_i = 1'b1;
      reset_ni = 1'b0;
      #1;
      check("mrst_cyc", bus.i_cyc_o, 1'b0);
      check("mrst_fack", f_ack_o, 1'b0);
      check("mrst_adr", bus.i_adr_o, 64'h100);
      next_cyc();
      reset_ni = 1'b1;
      next_cyc();
      bus.i_ack_i = 1'b1; bus.i_dat_i = 32'h0000_0013;
      settle();
      check("mrst_adr2", bus.i_adr_o, 64'h100);
      check("mrst_fack2", f_ack_o, 1'b1);
      check("mrst_pc2", f_pc_o, 64'h100);
      next_cyc();
      settle();
      check("mrst_next", bus.i_adr_o, 64'h104);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/stage_f.md
# stage_f

Instruction fetch stage of the Polaris pipeline, the producer side of the F-bus consumed by `stage_d`. It owns the program counter and runs Wishbone-classic single-beat reads of 32-bit instructions from instruction memory. Each completed read is presented to the decoder as a one-cycle `f_ack_o` strobe with data. It also accepts control-flow redirects from the execute stage and discards in-flight fetches made stale by a redirect.

## Interface
- `RESET_PC`, default 64'h0000_0000_0000_0100: first fetch address after reset.
- `clk_i`  in  1  pipeline clock; all state changes on the rising edge.
- `reset_ni`  in  1  asynchronous, active-low reset.
- `i_adr_o`  out  64  instruction bus address (always equals internal PC).
- `i_cyc_o`  out  1  bus cycle in progress.
- `i_stb_o`  out  1  strobe; always equal to `i_cyc_o`.
- `i_ack_i`  in  1  memory acknowledge; may arrive in the same cycle `stb` rises (zero-wait).
- `i_dat_i`  in  32  instruction word, valid with `i_ack_i`.
- `i_err_i`  in  1  bus error (see Configuration).
- `x_redirect_i`  in  1  one-cycle redirect request from execute.
- `x_pc_i`  in  64  redirect target, valid with `x_redirect_i`.
- `f_ack_o`  out  1  instruction valid to decoder (drives `f_ack_i`).
- `f_dat_o`  out  32  instruction to decoder (drives `f_dat_i`); equals `i_dat_i`.
- `f_pc_o`  out  64  address of the instruction on `f_dat_o`.
- `f_misalign_o`  out  1  fetching halted on a target with `[1:0]` != 0.
- `f_fault_o`  out  1  fetching halted on a bus error.

## Operation
- States: IDLE, FETCH, HALT.
- Reset (async, while `reset_ni`=0):
  - State=IDLE, PC=`RESET_PC`.
  - Pending flag=0, `i_cyc_o`=`i_stb_o`=0, `f_ack_o`=0, `f_misalign_o`=`f_fault_o`=0.
  - `i_adr_o`=`RESET_PC`.
- IDLE goes to FETCH on the first clock edge after reset release.
- FETCH drives `cyc`/`stb`=1 with `i_adr_o`=PC. Address and strobe are held stable until `i_ack_i` (or `i_err_i`).
- Accepted ack (`i_ack_i`=1, no pending flag, no `x_redirect_i` this cycle):
  - `f_ack_o`=1 combinationally; `f_dat_o`=`i_dat_i`, `f_pc_o`=PC.
  - Next edge: PC<=PC+4 (64-bit wrap). `cyc` stays high, so back-to-back zero-wait acks give one instruction per cycle.
- Redirect with no ack in the same cycle: pending flag<=1, pending target<=`x_pc_i`. The bus cycle continues unchanged. If a second redirect arrives while pending, the latest target wins.
- Ack while pending, or ack coinciding with `x_redirect_i`:
  - `f_ack_o`=0 (fetch discarded).
  - Next edge: PC<=target (the coinciding `x_pc_i` takes priority over the stored one); pending<=0.
- Redirect in IDLE or HALT takes effect at the next edge: PC<=target. State goes to FETCH, or to HALT if misaligned. `f_misalign_o` and `f_fault_o` clear.
- Misaligned target (`target[1:0]`!=0) when loaded into PC:
  - State<=HALT, `f_misalign_o`<=1, `cyc`<=0.
  - PC holds the misaligned target, which is visible on `i_adr_o`.
- HALT: no bus activity and `f_ack_o`=0. Exits only via redirect or reset.
- `f_ack_o` is never asserted outside FETCH and never without `i_ack_i`.

## Timing
- Address-to-decoder latency is 0 cycles after `i_ack_i`. Decoder registration adds 1 cycle.
- First `stb` rises one cycle after reset release.
- Redirect penalty, zero-wait memory: the new-target `stb` begins the edge after the redirect. The instruction in the redirect cycle is suppressed.
- Redirect penalty, wait-state memory: the new target is issued the edge after the stale ack.
- Reset asserted mid-cycle drops `cyc`/`stb` immediately (asynchronously). The in-flight ack is ignored and the pending flag is cleared.
- `f_misalign_o` and `f_fault_o` are registered; they assert the edge after the triggering event.

## Configuration
- `STAGE_F_BUS_ERR_EN` defined:
  - `i_err_i`=1 in FETCH with no pending flag: `f_ack_o`=0; next edge State<=HALT, `f_fault_o`<=1, `cyc`<=0.
  - An error on a stale (pending) fetch is discarded like a stale ack, and the redirect proceeds.
- Not defined: `i_err_i` is ignored, `f_fault_o` is tied 0, and fetch waits for `i_ack_i` only.

## Test plan
- Reset low for 2 cycles, then release: `i_cyc_o`=0 during reset; one cycle later `cyc`=`stb`=1 and `i_adr_o`=0x100.
- Zero-wait memory returning 0x00000013, 0x00410113, 0x00208033: `f_ack_o` high for 3 consecutive cycles, `f_pc_o`=0x100, 0x104, 0x108 with matching `f_dat_o`.
- Memory with 2 wait states: `i_adr_o` stays 0x100 and `f_ack_o`=0 for 2 cycles, then `f_ack_o`=1 for exactly 1 cycle, then `i_adr_o`=0x104.
- Redirect to 0x2000 during a wait state, then ack with 0xFFFFFFFF: `f_ack_o` stays 0; next `i_adr_o`=0x2000; following ack gives `f_pc_o`=0x2000.
- Redirect to 0x2002: `f_misalign_o`=1, `cyc`=0, and no `f_ack_o` for 5 idle cycles. Then redirect to 0x3000: `f_misalign_o`=0 and `i_adr_o`=0x3000 with `cyc`=1.
- With `STAGE_F_BUS_ERR_EN`, `i_err_i` pulsed at 0x104: `f_ack_o`=0, `f_fault_o`=1, `cyc`=0. Without the macro, the same stimulus has no effect and fetch resumes on the next `i_ack_i`.
